// File: rtl/fpu_pkg.sv
// Shared constants, enumerations and operand-split helpers for the FPU batch sequencer.
package fpu_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 14;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [OP_W-1:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_MIN  = 3'd4,
    FPU_MAX  = 3'd5,
    FPU_SQRT = 3'd6,
    FPU_CMP  = 3'd7
  } fpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } seq_state_e;

  // Operand A lives in the upper half of each memory word.
  function automatic logic [DATA_W-1:0] opnd_a(input logic [2*DATA_W-1:0] word);
    return word[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] opnd_b(input logic [2*DATA_W-1:0] word);
    return word[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_seq_counter.sv
// Address / index / remaining counters for one batch; address wraps at the memory size.
module fpu_seq_counter
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  idx,
  output logic              last
);

  logic [CNT_W-1:0] remaining_r;

  // Load on batch start, step once per delivered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr        <= '0;
      idx         <= '0;
      remaining_r <= '0;
    end else if (load) begin
      addr        <= base;
      idx         <= '0;
      remaining_r <= len;
    end else if (adv) begin
      addr        <= addr + ADDR_ONE;
      idx         <= idx + CNT_ONE;
      remaining_r <= remaining_r - CNT_ONE;
    end
  end

  // Final item of the batch is the one seen while exactly one remains.
  always_comb begin
    last = (remaining_r == CNT_ONE);
  end

endmodule

// File: rtl/fpu_batch_sequencer.sv
// Walks a contiguous range of operand-pair words, issues each pair to the FPU and
// forwards the indexed result downstream; one operation in flight at a time.
module fpu_batch_sequencer
  import fpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    count,
  input  logic [OP_W-1:0]     op,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [2*DATA_W-1:0] mem_data,
  output logic                fpu_valid,
  input  logic                fpu_ready,
  output logic [DATA_W-1:0]   fpu_a,
  output logic [DATA_W-1:0]   fpu_b,
  output logic [OP_W-1:0]     fpu_op,
  input  logic                fpu_res_valid,
  input  logic [DATA_W-1:0]   fpu_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]    out_idx,
  output logic                busy,
  output logic                done
);

  seq_state_e       state_r;
  logic             load_s;
  logic             adv_s;
  logic             last_s;
  logic [CNT_W-1:0] idx_s;

  // Counter control: load on an accepted start, advance on each output handshake.
  always_comb begin
    load_s = 1'b0;
    adv_s  = 1'b0;
    case (state_r)
      ST_IDLE: load_s = start;
      ST_EMIT: adv_s  = out_ready;
      default: begin
        load_s = 1'b0;
        adv_s  = 1'b0;
      end
    endcase
  end

  fpu_seq_counter u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .adv   (adv_s),
    .base  (base_addr),
    .len   (count),
    .addr  (mem_addr),
    .idx   (idx_s),
    .last  (last_s)
  );

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      fpu_valid <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            fpu_op <= op;
            // An empty batch completes immediately without touching the FPU.
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              state_r <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          fpu_a     <= opnd_a(mem_data);
          fpu_b     <= opnd_b(mem_data);
          fpu_valid <= 1'b1;
          state_r   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (fpu_ready) begin
            fpu_valid <= 1'b0;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fpu_res_valid) begin
            out_data  <= fpu_res;
            out_idx   <= idx_s;
            out_valid <= 1'b1;
            state_r   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_s) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_FETCH;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          fpu_valid <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_batch_sequencer.sv
// Randomised bench for fpu_batch_sequencer: a queue-based batch model plus an FPU
// and consumer model drive the handshakes; every handshake and status output is checked.
module tb_fpu_batch_sequencer;
  import fpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    count;
  logic [OP_W-1:0]     op;
  logic [ADDR_W-1:0]   mem_addr;
  logic [2*DATA_W-1:0] mem_data;
  logic                fpu_valid;
  logic                fpu_ready;
  logic [DATA_W-1:0]   fpu_a;
  logic [DATA_W-1:0]   fpu_b;
  logic [OP_W-1:0]     fpu_op;
  logic                fpu_res_valid;
  logic [DATA_W-1:0]   fpu_res;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [CNT_W-1:0]    out_idx;
  logic                busy;
  logic                done;

  logic [2*DATA_W-1:0] mem [0:8191];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  fpu_batch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .count         (count),
    .op            (op),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .fpu_valid     (fpu_valid),
    .fpu_ready     (fpu_ready),
    .fpu_a         (fpu_a),
    .fpu_b         (fpu_b),
    .fpu_op        (fpu_op),
    .fpu_res_valid (fpu_res_valid),
    .fpu_res       (fpu_res),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .busy          (busy),
    .done          (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            active = 1'b0;
  logic [63:0]   exp_q[$];
  int            exp_idx = 0;
  logic [12:0]   exp_base = 13'd0;
  logic [2:0]    exp_op = 3'd0;
  int            since_start = 0;
  // FPU / consumer model state
  int            latency = 2;
  bit            inflight = 1'b0;
  int            fcnt = 0;
  logic [63:0]   fres_pend = 64'd0;
  int            mode = 0;
  bit            spur_en = 1'b0;
  bit            junk_en = 1'b0;
  int            fv_wait = 0;
  int            ov_wait = 0;
  logic [63:0]   got_q[$];
  logic [12:0]   addr_log[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] fpu_fn(input logic [63:0] a, input logic [63:0] b, input logic [2:0] o);
    real ra;
    real rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (o)
      3'd0:    return $realtobits(ra + rb);
      3'd1:    return $realtobits(ra - rb);
      3'd2:    return $realtobits(ra * rb);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [63:0] rnd_dbl();
    return $realtobits(real'(int'($urandom_range(0, 2000)) - 1000) / 8.0);
  endfunction

  // One clock: note handshakes due at the coming edge, then check the new outputs.
  task automatic cycle();
    bit rs, fhs, ohs, sacc, pv, pov, last_hs, exp_done;
    logic [63:0] pa, pb, pod, expv;
    logic [CNT_W-1:0] poi;
    logic [12:0] ea;
    rs      = rst_n;
    fhs     = rs && fpu_valid && fpu_ready;
    ohs     = rs && out_valid && out_ready;
    sacc    = rs && start && !active;
    pv      = fpu_valid;
    pa      = fpu_a;
    pb      = fpu_b;
    pov     = out_valid;
    pod     = out_data;
    poi     = out_idx;
    last_hs = 1'b0;
    if (fhs) begin
      ea = exp_base + 13'(exp_idx);
      chk(mem_addr == ea, "mem_addr", 64'(mem_addr), 64'(ea));
      chk(fpu_a == mem[ea][127:64] && fpu_b == mem[ea][63:0], "operands", fpu_a, mem[ea][127:64]);
      chk(fpu_op == exp_op, "fpu_op", 64'(fpu_op), 64'(exp_op));
      addr_log.push_back(mem_addr);
      fres_pend = fpu_fn(fpu_a, fpu_b, fpu_op);
      fcnt      = latency;
      inflight  = 1'b1;
    end
    if (ohs) begin
      chk(exp_q.size() > 0, "extra_result", 64'(out_idx), 64'd0);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        chk(out_data == expv, "out_data", out_data, expv);
        chk(out_idx == CNT_W'(exp_idx), "out_idx", 64'(out_idx), 64'(exp_idx));
        got_q.push_back(out_data);
        exp_idx++;
        last_hs = (exp_q.size() == 0);
      end
    end
    @(posedge clk);
    #1;
    if (!rs) begin
      active = 1'b0;
      exp_q.delete();
      exp_idx = 0;
      inflight = 1'b0;
      since_start = 0;
      chk({mem_addr, fpu_valid, out_valid, busy, done, fpu_op, out_idx} == '0, "reset_ctrl",
          64'({mem_addr, fpu_valid, out_valid, busy, done, fpu_op, out_idx}), 64'd0);
      chk((fpu_a | fpu_b | out_data) == 64'd0, "reset_data", fpu_a | fpu_b | out_data, 64'd0);
    end else begin
      exp_done = 1'b0;
      if (sacc) begin
        if (count == 14'd0) begin
          exp_done = 1'b1;
        end else begin
          active   = 1'b1;
          exp_base = base_addr;
          exp_op   = op;
          exp_idx  = 0;
          since_start = 1;
          for (int i = 0; i < int'(count); i++) begin
            ea = base_addr + 13'(i);
            exp_q.push_back(fpu_fn(mem[ea][127:64], mem[ea][63:0], op));
          end
        end
      end
      if (ohs && last_hs) begin
        active   = 1'b0;
        exp_done = 1'b1;
      end
      chk(done == exp_done, "done", 64'(done), 64'(exp_done));
      chk(busy == active, "busy", 64'(busy), 64'(active));
      if (!active) chk(!fpu_valid && !out_valid, "idle_valids", 64'({fpu_valid, out_valid}), 64'd0);
      if (pv && !fhs) chk(fpu_valid && fpu_a == pa && fpu_b == pb, "fpu_hold", fpu_a, pa);
      if (fhs) chk(!fpu_valid, "fpu_drop", 64'(fpu_valid), 64'd0);
      if (pov && !ohs) chk(out_valid && out_data == pod && out_idx == poi, "out_hold", out_data, pod);
      if (ohs) chk(!out_valid, "out_drop", 64'(out_valid), 64'd0);
      if (since_start == 1) begin
        chk(!fpu_valid, "fetch_gap", 64'(fpu_valid), 64'd0);
        since_start = 2;
      end else if (since_start == 2) begin
        chk(fpu_valid, "first_valid", 64'(fpu_valid), 64'd1);
        since_start = 0;
      end
    end
    // FPU model: result after the programmed latency, otherwise optional noise.
    fpu_res_valid = 1'b0;
    fpu_res = {$urandom, $urandom};
    if (inflight) begin
      fcnt--;
      if (fcnt <= 0) begin
        fpu_res_valid = 1'b1;
        fpu_res = fres_pend;
        inflight = 1'b0;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      fpu_res_valid = 1'b1;
    end
    fv_wait = fpu_valid ? fv_wait + 1 : 0;
    ov_wait = out_valid ? ov_wait + 1 : 0;
    case (mode)
      0: begin fpu_ready = 1'b1; out_ready = 1'b1; end
      1: begin fpu_ready = ($urandom_range(0, 9) < 6); out_ready = ($urandom_range(0, 9) < 6); end
      default: begin fpu_ready = (fv_wait >= 6); out_ready = (ov_wait >= 5); end
    endcase
    start = 1'b0;
    if (junk_en && active && $urandom_range(0, 5) == 0) begin
      start = 1'b1;
      base_addr = 13'($urandom_range(0, 8191));
      count = 14'($urandom_range(0, 9));
      op = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic run_batch(input logic [12:0] b, input logic [13:0] n, input logic [2:0] o, input int lat);
    int budget;
    latency = lat;
    start = 1'b1;
    base_addr = b;
    count = n;
    op = o;
    cycle();
    budget = 0;
    while (active && budget < 3000) begin
      cycle();
      budget++;
    end
    if (active) begin
      chk(1'b0, "batch_timeout", 64'(exp_idx), 64'(n));
      active = 1'b0;
      exp_q.delete();
    end
    cycle();
  endtask

  initial begin
    logic [63:0] lit [4];
    int budget;
    lit[0] = 64'h4014_90FD_AA22_168C;
    lit[1] = 64'hC000_0000_0000_0000;
    lit[2] = 64'h4000_0000_0000_0000;
    lit[3] = 64'h4008_0000_0000_0000;
    for (int i = 0; i < 8192; i++) mem[i] = {rnd_dbl(), rnd_dbl()};
    mem[0] = {64'h4009_21FB_5444_2D18, 64'h4000_0000_0000_0000};
    mem[1] = {64'hC008_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    mem[2] = {64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    mem[3] = {64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 13'd0;
    count = 14'd0;
    op = 3'd0;
    fpu_ready = 1'b1;
    out_ready = 1'b1;
    fpu_res_valid = 1'b0;
    fpu_res = 64'd0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Pi/2, -3/1, 1/1, 2/1 added pairwise.
    got_q.delete();
    run_batch(13'd0, 14'd4, 3'd0, 2);
    chk(got_q.size() == 4, "t1_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk(got_q[i] == lit[i], "t1_literal", got_q[i], lit[i]);
    end

    // Empty batch.
    run_batch(13'd5, 14'd0, 3'd1, 2);

    // Address wrap.
    addr_log.delete();
    run_batch(13'd8190, 14'd3, 3'd2, 1);
    chk(addr_log.size() == 3, "t3_count", 64'(addr_log.size()), 64'd3);
    if (addr_log.size() == 3) begin
      chk(addr_log[0] == 13'd8190 && addr_log[1] == 13'd8191 && addr_log[2] == 13'd0, "t3_wrap",
          64'({addr_log[0], addr_log[1], addr_log[2]}), 64'({13'd8190, 13'd8191, 13'd0}));
    end

    // Back-pressure on both handshakes.
    mode = 2;
    run_batch(13'd100, 14'd3, 3'd1, 2);

    // Mid-batch start and stray results.
    mode = 0;
    spur_en = 1'b1;
    junk_en = 1'b1;
    run_batch(13'd200, 14'd5, 3'd0, 3);
    junk_en = 1'b0;
    spur_en = 1'b0;

    // Reset while waiting on the second item's result.
    latency = 3;
    start = 1'b1;
    base_addr = 13'd0;
    count = 14'd4;
    op = 3'd0;
    cycle();
    budget = 0;
    while (!(exp_idx == 1 && inflight) && budget < 200) begin
      cycle();
      budget++;
    end
    chk(exp_idx == 1 && inflight, "t6_reach_wait", 64'(exp_idx), 64'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    got_q.delete();
    run_batch(13'd0, 14'd4, 3'd0, 2);
    chk(got_q.size() == 4 && got_q[0] == lit[0], "t6_rerun", got_q.size() > 0 ? got_q[0] : 64'd0, lit[0]);

    // Randomised batches with random stalls, noise and ignored starts.
    mode = 1;
    spur_en = 1'b1;
    junk_en = 1'b1;
    for (int t = 0; t < 20; t++) begin
      run_batch(13'($urandom_range(0, 1) == 0 ? $urandom_range(8185, 8191) : $urandom_range(0, 8191)),
                14'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
